// File: rtl/controle_acumulador.sv
// controle_acumulador: command sequencer for the 5-bit accumulator register.
// Expands one high-level command (load, clear, shift-right by N) into the
// per-cycle T codes the register expects and pulses done on completion.
// Optional feature macro: CONTROLE_SERIAL_EN. When it is defined, a shadow
// copy of the accumulator is kept and the shifted-out bits are streamed on
// serial_out_o, LSB first. When it is undefined, both serial outputs are
// tied to 0.
module controle_acumulador #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [CNT_W-1:0] n_shift_i,
  input  logic [WIDTH-1:0] dado_i,
  output logic [4:0]       T_o,
  output logic [WIDTH-1:0] entrada_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             serial_out_o,
  output logic             serial_valid_o
);

  // Register command codes
  localparam logic [4:0] T_HOLD  = 5'd0;
  localparam logic [4:0] T_LOAD  = 5'd1;
  localparam logic [4:0] T_RESET = 5'd2;
  localparam logic [4:0] T_SHIFT = 5'd3;

  // Command opcodes
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       t_q;
  logic [WIDTH-1:0] entrada_q;
  logic             busy_q;
  logic             done_q;

  // Sequencer: state, shift counter and all registered outputs. The output
  // registers are loaded on the same edge as the state transition so that a
  // command accepted at edge k shows its T code in cycle k+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      t_q       <= T_HOLD;
      entrada_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          t_q    <= T_HOLD;
          busy_q <= 1'b0;
          if (start_i) begin
            entrada_q <= dado_i;
            cnt_q     <= n_shift_i;
            case (op_i)
              OP_LOAD: begin
                state_q <= S_LOAD;
                t_q     <= T_LOAD;
                busy_q  <= 1'b1;
              end
              OP_CLEAR: begin
                state_q <= S_CLEAR;
                t_q     <= T_RESET;
                busy_q  <= 1'b1;
              end
              OP_SHIFT: begin
                if (n_shift_i != '0) begin
                  state_q <= S_SHIFT;
                  t_q     <= T_SHIFT;
                  busy_q  <= 1'b1;
                end else begin
                  // Zero-length shift completes like a nop.
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end
              end
              default: begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        S_LOAD, S_CLEAR: begin
          state_q <= S_DONE;
          t_q     <= T_HOLD;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_SHIFT: begin
          // cnt_q holds the number of shift cycles still to be shown,
          // including the current one.
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_q <= S_DONE;
            t_q     <= T_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          t_q     <= T_HOLD;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          t_q     <= T_HOLD;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign T_o       = t_q;
  assign entrada_o = entrada_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

`ifdef CONTROLE_SERIAL_EN
  logic [WIDTH-1:0] shadow_q;
  logic             serial_out_q;
  logic             serial_valid_q;
  logic             shift_issue;

  // A shift cycle is being scheduled for the next cycle: either a non-zero
  // shift is accepted, or a running shift has more than one cycle left.
  assign shift_issue = ((state_q == S_IDLE) && start_i && (op_i == OP_SHIFT) &&
                        (n_shift_i != '0)) ||
                       ((state_q == S_SHIFT) &&
                        (cnt_q != {{(CNT_W-1){1'b0}}, 1'b1}));

  // Shadow tracks what the accumulator will hold once the scheduled T code
  // has executed; the bit presented on serial_out is the LSB before the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q       <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
    end else begin
      serial_valid_q <= 1'b0;
      if (shift_issue) begin
        serial_out_q   <= shadow_q[0];
        serial_valid_q <= 1'b1;
        shadow_q       <= shadow_q >> 1;
      end else if ((state_q == S_IDLE) && start_i && (op_i == OP_LOAD)) begin
        shadow_q <= dado_i;
      end else if ((state_q == S_IDLE) && start_i && (op_i == OP_CLEAR)) begin
        shadow_q <= '0;
      end
    end
  end

  assign serial_out_o   = serial_out_q;
  assign serial_valid_o = serial_valid_q;
`else
  assign serial_out_o   = 1'b0;
  assign serial_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_controle_acumulador.sv
// Directed testbench for controle_acumulador.
module tb_controle_acumulador;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [1:0] op_i;
  logic [2:0] n_shift_i;
  logic [4:0] dado_i;
  logic [4:0] T_o;
  logic [4:0] entrada_o;
  logic       busy_o;
  logic       done_o;
  logic       serial_out_o;
  logic       serial_valid_o;

  int checks;
  int failures;

  controle_acumulador #(.WIDTH(5), .CNT_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .op_i           (op_i),
    .n_shift_i      (n_shift_i),
    .dado_i         (dado_i),
    .T_o            (T_o),
    .entrada_o      (entrada_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .serial_out_o   (serial_out_o),
    .serial_valid_o (serial_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge, then drop start.
  task automatic issue(input logic [1:0] op, input logic [2:0] n, input logic [4:0] d);
    start_i   = 1'b1;
    op_i      = op;
    n_shift_i = n;
    dado_i    = d;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start_i   = 1'b1;
    op_i      = 2'b01;
    dado_i    = 5'b11111;
    n_shift_i = 3'd0;
    repeat (3) cyc();
    checks++;
    if (T_o !== 5'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || entrada_o !== 5'd0) begin
      failures++;
      $display("FAIL reset_hold: T=%0d busy=%b done=%b entrada=%b, want 0/0/0/00000",
               T_o, busy_o, done_o, entrada_o);
    end
    start_i = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (T_o !== 5'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || entrada_o !== 5'd0 ||
          serial_out_o !== 1'b0 || serial_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: T=%0d busy=%b done=%b entrada=%b sout=%b sval=%b, want all 0",
                 i, T_o, busy_o, done_o, entrada_o, serial_out_o, serial_valid_o);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_load();
    issue(2'b01, 3'd0, 5'b10110);
    checks++;
    if (T_o !== 5'd1 || entrada_o !== 5'b10110 || busy_o !== 1'b1 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL load_k1: T=%0d entrada=%b busy=%b done=%b, want 1/10110/1/0",
               T_o, entrada_o, busy_o, done_o);
    end
    cyc();
    checks++;
    if (T_o !== 5'd0 || busy_o !== 1'b0 || done_o !== 1'b1) begin
      failures++;
      $display("FAIL load_k2: T=%0d busy=%b done=%b, want 0/0/1", T_o, busy_o, done_o);
    end
    cyc();
    checks++;
    if (T_o !== 5'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL load_k3: T=%0d busy=%b done=%b, want 0/0/0", T_o, busy_o, done_o);
    end
    $display("test_load: load 10110");
  endtask

  task automatic test_load_shift();
    logic [2:0] exp_bits;
    exp_bits = 3'b011; // bit i = expected serial bit in shift cycle i: 1,1,0
    issue(2'b01, 3'd0, 5'b01011);
    cyc();
    checks++;
    if (done_o !== 1'b1) begin
      failures++;
      $display("FAIL ls_load_done: done=%b, want 1", done_o);
    end
    cyc();
    issue(2'b11, 3'd3, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (T_o !== 5'd3 || busy_o !== 1'b1 || done_o !== 1'b0) begin
        failures++;
        $display("FAIL shift3_cyc%0d: T=%0d busy=%b done=%b, want 3/1/0", i, T_o, busy_o, done_o);
      end
`ifdef CONTROLE_SERIAL_EN
      checks++;
      if (serial_valid_o !== 1'b1 || serial_out_o !== exp_bits[i]) begin
        failures++;
        $display("FAIL serial_cyc%0d: valid=%b out=%b, want 1/%b", i, serial_valid_o,
                 serial_out_o, exp_bits[i]);
      end
`else
      checks++;
      if (serial_valid_o !== 1'b0 || serial_out_o !== 1'b0) begin
        failures++;
        $display("FAIL serial_off_cyc%0d: valid=%b out=%b, want 0/0 (expected bit %b unused)",
                 i, serial_valid_o, serial_out_o, exp_bits[i]);
      end
`endif
      cyc();
    end
    checks++;
    if (T_o !== 5'd0 || busy_o !== 1'b0 || done_o !== 1'b1 || serial_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL shift3_done: T=%0d busy=%b done=%b sval=%b, want 0/0/1/0",
               T_o, busy_o, done_o, serial_valid_o);
    end
    cyc();
    $display("test_load_shift: load 01011 then shift 3");
  endtask

  task automatic test_zero_and_nop();
    issue(2'b11, 3'd0, 5'b00000);
    checks++;
    if (T_o !== 5'd0 || busy_o !== 1'b0 || done_o !== 1'b1) begin
      failures++;
      $display("FAIL shift0: T=%0d busy=%b done=%b, want 0/0/1", T_o, busy_o, done_o);
    end
    cyc();
    checks++;
    if (T_o !== 5'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL shift0_after: T=%0d busy=%b done=%b, want 0/0/0", T_o, busy_o, done_o);
    end
    issue(2'b00, 3'd5, 5'b11111);
    checks++;
    if (T_o !== 5'd0 || busy_o !== 1'b0 || done_o !== 1'b1) begin
      failures++;
      $display("FAIL nop: T=%0d busy=%b done=%b, want 0/0/1", T_o, busy_o, done_o);
    end
    cyc();
    checks++;
    if (T_o !== 5'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL nop_after: T=%0d busy=%b done=%b, want 0/0/0", T_o, busy_o, done_o);
    end
    $display("test_zero_and_nop: shift 0 and nop");
  endtask

  task automatic test_back_to_back();
    int clr_count;
    issue(2'b11, 3'd5, 5'b00000);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        start_i = 1'b1;
        op_i    = 2'b10;
      end else begin
        start_i = 1'b0;
      end
      checks++;
      if (T_o !== 5'd3 || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL busy_shift5_cyc%0d: T=%0d busy=%b, want 3/1", i, T_o, busy_o);
      end
      cyc();
    end
    start_i = 1'b0;
    checks++;
    if (T_o !== 5'd0 || done_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL shift5_done: T=%0d done=%b busy=%b, want 0/1/0", T_o, done_o, busy_o);
    end
    cyc();
    checks++;
    if (T_o !== 5'd0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL ignored_clear: T=%0d done=%b busy=%b, want 0/0/0", T_o, done_o, busy_o);
    end
    issue(2'b10, 3'd0, 5'b00000);
    clr_count = 0;
    checks++;
    if (T_o !== 5'd2 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL clear_k1: T=%0d busy=%b, want 2/1", T_o, busy_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (T_o === 5'd2) clr_count++;
      cyc();
    end
    checks++;
    if (clr_count !== 1) begin
      failures++;
      $display("FAIL clear_once: T=2 seen %0d times, want 1", clr_count);
    end
    $display("test_back_to_back: clear during shift ignored, then clear");
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    issue(2'b11, 3'd6, 5'b00000);
    cyc(); // now in 2nd shift cycle
    checks++;
    if (T_o !== 5'd3) begin
      failures++;
      $display("FAIL abort_pre: T=%0d, want 3", T_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (T_o !== 5'd0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_async: T=%0d busy=%b, want 0/0", T_o, busy_o);
    end
    saw_done = 1'b0;
    repeat (2) begin
      cyc();
      if (done_o === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (8) begin
      cyc();
      if (done_o === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: done seen=%b, want 0", saw_done);
    end
    issue(2'b01, 3'd0, 5'b00111);
    checks++;
    if (T_o !== 5'd1 || entrada_o !== 5'b00111 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_reload: T=%0d entrada=%b busy=%b, want 1/00111/1",
               T_o, entrada_o, busy_o);
    end
    cyc();
    checks++;
    if (done_o !== 1'b1 || T_o !== 5'd0) begin
      failures++;
      $display("FAIL abort_reload_done: done=%b T=%0d, want 1/0", done_o, T_o);
    end
    cyc();
    $display("test_reset_abort: reset mid-shift, then load");
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start_i   = 1'b0;
    op_i      = 2'b00;
    n_shift_i = 3'd0;
    dado_i    = 5'd0;
    #2;
    test_reset();
    test_load();
    test_load_shift();
    test_zero_and_nop();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
